alu_issue_stage: RTL and testbench
==================================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have clk, input, 1, single rising-edge clock.
REQ-002 SHALL have rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have id_valid, input, 1, decoded instruction present.
REQ-004 SHALL have id_instr, input, 32, raw RV32I instruction.
REQ-005 SHALL have id_pc, id_rs1_data, id_rs2_data, id_imm, input, 32 each, PC, register-file reads, sign-extended immediate.
REQ-006 SHALL have exm_rd, mwb_rd, input, 5 each, with exm_regwrite and mwb_regwrite, input, 1 each; also exm_result and mwb_result, input, 32 each; these are the forwarding sources.
REQ-007 SHALL have exm_is_load, input, 1, EX/MEM result not yet available.
REQ-008 SHALL have flush, input, 1, squash the next issue.
REQ-009 SHALL have ex_stall, input, 1, downstream hold.
REQ-010 SHALL have ex_valid, ex_funct[2:0], ex_op1[31:0], ex_op2[31:0], ex_ALUcntl[3:0], ex_rd[4:0], ex_regwrite, ex_is_load, output, registered ALU-side operands and control.
REQ-011 SHALL have stall_req, output, 1, combinational request that ID hold.
REQ-012 SHALL have illegal, output, 1, registered unsupported-opcode flag.

Function
REQ-013 SHALL encode ALUcntl as AND 0000, OR 0001, XOR 0010, SLL 0011, SRL 0100, SRA 0101, ADD 0110, SUB/compare 0111.
REQ-014 SHALL map OP/OP-IMM by funct3 and instr[30] as follows: ADD/ADDI to 0110; SUB to 0111 with funct 000; SLT(I) to 0111 with funct 010; SLTU(I) to 0111 with funct 011.
REQ-015 SHALL issue shifts with ex_op2 = {27'b0, operand[4:0]}, because the ALU shifts by the full op2.
REQ-016 SHALL map LOAD, STORE to ADD(rs1, imm); LUI to ADD(0, imm); AUIPC to ADD(pc, imm); JAL/JALR to ADD(pc, 4); BRANCH to 0111(rs1, rs2) with funct = instr funct3.
REQ-017 SHALL, for any other opcode, issue ADD(0, 0) with ex_regwrite=0 and illegal=1.
REQ-018 SHALL forward each rs: EX/MEM wins over MEM/WB, and each source is used only when its regwrite=1 and its rd equals the source rs; rd=0 is never forwarded; otherwise register-file data is used.
REQ-019 SHALL assert stall_req when id_valid, exm_is_load, ex_valid, exm_rd!=0 and exm_rd matches a used rs1/rs2; the next edge then loads a bubble (ex_valid=0, ex_regwrite=0), so the load-use penalty is exactly 1 cycle.
REQ-020 SHALL, when ex_stall=1, hold all ex_* outputs unchanged, ignore the ID inputs, and force stall_req=1.
REQ-021 SHALL give flush priority over everything except reset: the next edge loads a bubble even if ex_stall=1.
REQ-022 SHALL have an issue latency of one clock from ID inputs to ex_* outputs.
REQ-023 SHALL drive ex_funct=funct3 for every non-compare op; a bubble carries funct 000 and ALUcntl 0110.

Reset
REQ-024 SHALL asynchronously clear all ex_* outputs and illegal to zero on rst_n=0, except ex_ALUcntl=0110.
REQ-025 SHALL not assert stall_req while in reset; the first issue occurs on the first edge after release.
REQ-026 SHALL discard any in-flight issue on reset mid-operation, with no replay.

Structure
REQ-027 SHALL take the ALUcntl encodings, RV32I opcode constants and funct3 compare codes from shared package alu_pkg.
REQ-028 SHALL place the opcode/funct-to-ALUcntl mapping in combinational sub-module alu_decode; forwarding, hazard logic and registers stay in alu_issue_stage.

Verification
REQ-029 SHALL verify: SUB x3,x1,x2 with x1=5, x2=7 -> next cycle ex_ALUcntl=0111, ex_funct=000, ex_op1=5, ex_op2=7.
REQ-030 SHALL verify: SLLI rs1=1, imm=0x25 -> ex_ALUcntl=0011, ex_op2=5.
REQ-031 SHALL verify: exm_rd=mwb_rd=3, both regwrite, exm_result=0xAA, mwb_result=0xBB, rs1=3 -> ex_op1=0xAA.
REQ-032 SHALL verify: LW x4 issued, then ADD x5,x4,x4 -> stall_req=1 for one cycle, one bubble, then ADD issues with forwarded data.
REQ-033 SHALL verify: flush and ex_stall both 1 with a valid ID instruction -> ex_valid=0 next cycle.
REQ-034 SHALL verify: rst_n low mid-stream -> ex_valid=0, ex_ALUcntl=0110 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU control encodings, RV32I opcode/funct3 constants and the
// issue-register bundle used by the ALU issue stage.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_XOR = 4'b0010,
    ALU_SLL = 4'b0011,
    ALU_SRL = 4'b0100,
    ALU_SRA = 4'b0101,
    ALU_ADD = 4'b0110,
    ALU_SUB = 4'b0111
  } alu_cntl_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  typedef enum logic [1:0] {
    OP1_RS1  = 2'd0,
    OP1_PC   = 2'd1,
    OP1_ZERO = 2'd2
  } op1_sel_e;

  typedef enum logic [1:0] {
    OP2_RS2  = 2'd0,
    OP2_IMM  = 2'd1,
    OP2_FOUR = 2'd2,
    OP2_ZERO = 2'd3
  } op2_sel_e;

  typedef struct packed {
    logic        valid;
    logic [2:0]  funct;
    logic [31:0] op1;
    logic [31:0] op2;
    alu_cntl_e   alu_cntl;
    logic [4:0]  rd;
    logic        regwrite;
    logic        is_load;
    logic        illegal;
  } issue_t;

  // A bubble is also the reset image of the issue register.
  localparam issue_t ISSUE_BUBBLE = '{
    valid:    1'b0,
    funct:    3'b000,
    op1:      32'h0,
    op2:      32'h0,
    alu_cntl: ALU_ADD,
    rd:       5'd0,
    regwrite: 1'b0,
    is_load:  1'b0,
    illegal:  1'b0
  };

endpackage

// File: rtl/alu_decode.sv
// Combinational opcode/funct3 to ALU control decode: selects operand sources,
// the ALU operation and the write-back/load/illegal attributes.
module alu_decode
  import alu_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_alt,
  output logic [3:0] o_alu_cntl,
  output logic [1:0] o_op1_sel,
  output logic [1:0] o_op2_sel,
  output logic       o_shift,
  output logic       o_uses_rs1,
  output logic       o_uses_rs2,
  output logic       o_regwrite,
  output logic       o_is_load,
  output logic       o_illegal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    o_alu_cntl = ALU_ADD;
    o_op1_sel  = OP1_ZERO;
    o_op2_sel  = OP2_ZERO;
    o_shift    = 1'b0;
    o_uses_rs1 = 1'b0;
    o_uses_rs2 = 1'b0;
    o_regwrite = 1'b0;
    o_is_load  = 1'b0;
    o_illegal  = 1'b0;

    case (i_opcode)
      OPC_OP, OPC_OP_IMM: begin
        o_op1_sel  = OP1_RS1;
        o_uses_rs1 = 1'b1;
        o_op2_sel  = (i_opcode == OPC_OP) ? OP2_RS2 : OP2_IMM;
        o_uses_rs2 = (i_opcode == OPC_OP);
        o_regwrite = 1'b1;
        case (i_funct3)
          // instr[30] selects SUB only for register-register ops; ADDI has no SUBI.
          F3_ADD_SUB: o_alu_cntl = (i_opcode == OPC_OP && i_alt) ? ALU_SUB : ALU_ADD;
          F3_SLL: begin
            o_alu_cntl = ALU_SLL;
            o_shift    = 1'b1;
          end
          F3_SLT, F3_SLTU: o_alu_cntl = ALU_SUB;
          F3_XOR:          o_alu_cntl = ALU_XOR;
          F3_SR: begin
            o_alu_cntl = i_alt ? ALU_SRA : ALU_SRL;
            o_shift    = 1'b1;
          end
          F3_OR:           o_alu_cntl = ALU_OR;
          default:         o_alu_cntl = ALU_AND;
        endcase
      end
      OPC_LOAD: begin
        o_op1_sel  = OP1_RS1;
        o_op2_sel  = OP2_IMM;
        o_uses_rs1 = 1'b1;
        o_regwrite = 1'b1;
        o_is_load  = 1'b1;
      end
      OPC_STORE: begin
        o_op1_sel  = OP1_RS1;
        o_op2_sel  = OP2_IMM;
        o_uses_rs1 = 1'b1;
      end
      OPC_LUI: begin
        o_op2_sel  = OP2_IMM;
        o_regwrite = 1'b1;
      end
      OPC_AUIPC: begin
        o_op1_sel  = OP1_PC;
        o_op2_sel  = OP2_IMM;
        o_regwrite = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        o_op1_sel  = OP1_PC;
        o_op2_sel  = OP2_FOUR;
        o_regwrite = 1'b1;
      end
      OPC_BRANCH: begin
        o_alu_cntl = ALU_SUB;
        o_op1_sel  = OP1_RS1;
        o_op2_sel  = OP2_RS2;
        o_uses_rs1 = 1'b1;
        o_uses_rs2 = 1'b1;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID-to-EX issue register for the ALU: operand forwarding, load-use hazard
// detection, stall/flush handling and the registered ALU-side controls.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  exm_rd,
  input  logic [4:0]  mwb_rd,
  input  logic        exm_regwrite,
  input  logic        mwb_regwrite,
  input  logic [31:0] exm_result,
  input  logic [31:0] mwb_result,
  input  logic        exm_is_load,
  input  logic        flush,
  input  logic        ex_stall,
  output logic        ex_valid,
  output logic [2:0]  ex_funct,
  output logic [31:0] ex_op1,
  output logic [31:0] ex_op2,
  output logic [3:0]  ex_ALUcntl,
  output logic [4:0]  ex_rd,
  output logic        ex_regwrite,
  output logic        ex_is_load,
  output logic        stall_req,
  output logic        illegal
);

  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;
  logic        w_unused_instr_bits;
  logic [3:0]  w_alu_cntl;
  logic [1:0]  w_op1_sel;
  logic [1:0]  w_op2_sel;
  logic        w_shift;
  logic        w_uses_rs1;
  logic        w_uses_rs2;
  logic        w_regwrite;
  logic        w_is_load;
  logic        w_illegal;
  logic [31:0] w_fwd_rs1;
  logic [31:0] w_fwd_rs2;
  logic [31:0] w_op1;
  logic [31:0] w_op2_raw;
  logic [31:0] w_op2;
  logic        w_load_use;
  issue_t      w_issue;
  issue_t      r_ex;

  assign w_rs1 = id_instr[19:15];
  assign w_rs2 = id_instr[24:20];
  assign w_rd  = id_instr[11:7];
  assign w_unused_instr_bits = &{1'b0, id_instr[31], id_instr[29:25]};

  alu_decode u_decode (
    .i_opcode   (id_instr[6:0]),
    .i_funct3   (id_instr[14:12]),
    .i_alt      (id_instr[30]),
    .o_alu_cntl (w_alu_cntl),
    .o_op1_sel  (w_op1_sel),
    .o_op2_sel  (w_op2_sel),
    .o_shift    (w_shift),
    .o_uses_rs1 (w_uses_rs1),
    .o_uses_rs2 (w_uses_rs2),
    .o_regwrite (w_regwrite),
    .o_is_load  (w_is_load),
    .o_illegal  (w_illegal)
  );

  // The younger producer (EX/MEM) has the newer value, so it wins over MEM/WB.
  always_comb begin
    w_fwd_rs1 = id_rs1_data;
    if (exm_regwrite && exm_rd != 5'd0 && exm_rd == w_rs1)
      w_fwd_rs1 = exm_result;
    else if (mwb_regwrite && mwb_rd != 5'd0 && mwb_rd == w_rs1)
      w_fwd_rs1 = mwb_result;

    w_fwd_rs2 = id_rs2_data;
    if (exm_regwrite && exm_rd != 5'd0 && exm_rd == w_rs2)
      w_fwd_rs2 = exm_result;
    else if (mwb_regwrite && mwb_rd != 5'd0 && mwb_rd == w_rs2)
      w_fwd_rs2 = mwb_result;
  end

  always_comb begin
    case (op1_sel_e'(w_op1_sel))
      OP1_RS1: w_op1 = w_fwd_rs1;
      OP1_PC:  w_op1 = id_pc;
      default: w_op1 = 32'h0;
    endcase

    case (op2_sel_e'(w_op2_sel))
      OP2_RS2:  w_op2_raw = w_fwd_rs2;
      OP2_IMM:  w_op2_raw = id_imm;
      OP2_FOUR: w_op2_raw = 32'd4;
      default:  w_op2_raw = 32'h0;
    endcase

    // The ALU shifts by all of op2, so only the 5-bit shift amount is passed on.
    w_op2 = w_shift ? {27'b0, w_op2_raw[4:0]} : w_op2_raw;
  end

  always_comb begin
    w_issue          = ISSUE_BUBBLE;
    w_issue.valid    = 1'b1;
    w_issue.funct    = id_instr[14:12];
    w_issue.op1      = w_op1;
    w_issue.op2      = w_op2;
    w_issue.alu_cntl = alu_cntl_e'(w_alu_cntl);
    w_issue.rd       = w_rd;
    w_issue.regwrite = w_regwrite;
    w_issue.is_load  = w_is_load;
    w_issue.illegal  = w_illegal;
  end

  // A load sitting in EX/MEM has no result yet, so a dependent op must wait a cycle.
  assign w_load_use = id_valid && exm_is_load && r_ex.valid && (exm_rd != 5'd0) &&
                      ((w_uses_rs1 && exm_rd == w_rs1) || (w_uses_rs2 && exm_rd == w_rs2));

  assign stall_req = rst_n && (ex_stall || w_load_use);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n)
      r_ex <= ISSUE_BUBBLE;
    else if (flush)
      r_ex <= ISSUE_BUBBLE;
    else if (!ex_stall) begin
      if (w_load_use || !id_valid)
        r_ex <= ISSUE_BUBBLE;
      else
        r_ex <= w_issue;
    end
  end

  assign ex_valid    = r_ex.valid;
  assign ex_funct    = r_ex.funct;
  assign ex_op1      = r_ex.op1;
  assign ex_op2      = r_ex.op2;
  assign ex_ALUcntl  = r_ex.alu_cntl;
  assign ex_rd       = r_ex.rd;
  assign ex_regwrite = r_ex.regwrite;
  assign ex_is_load  = r_ex.is_load;
  assign illegal     = r_ex.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: a reference model pushes the
// expected issue per cycle to a scoreboard that is popped after each edge.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [31:0] id_instr = '0, id_pc = '0, id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
  logic [4:0]  exm_rd = '0, mwb_rd = '0;
  logic        exm_regwrite = 1'b0, mwb_regwrite = 1'b0;
  logic [31:0] exm_result = '0, mwb_result = '0;
  logic        exm_is_load = 1'b0, flush = 1'b0, ex_stall = 1'b0;
  logic        ex_valid, ex_regwrite, ex_is_load, stall_req, illegal;
  logic [2:0]  ex_funct;
  logic [31:0] ex_op1, ex_op2;
  logic [3:0]  ex_ALUcntl;
  logic [4:0]  ex_rd;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .exm_rd(exm_rd), .mwb_rd(mwb_rd), .exm_regwrite(exm_regwrite), .mwb_regwrite(mwb_regwrite),
    .exm_result(exm_result), .mwb_result(mwb_result), .exm_is_load(exm_is_load),
    .flush(flush), .ex_stall(ex_stall), .ex_valid(ex_valid), .ex_funct(ex_funct),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_ALUcntl(ex_ALUcntl), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load), .stall_req(stall_req), .illegal(illegal)
  );

  typedef struct {
    bit          bubble;
    logic        valid;
    logic [2:0]  funct;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  cntl;
    logic [4:0]  rd;
    logic        rw;
    logic        ld;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  exp_t        m_prev;
  logic [31:0] rf[32];
  logic [31:0] pc = 32'h100;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic exp_t bubble();
    exp_t e;
    e = '{bubble: 1'b1, valid: 1'b0, funct: 3'd0, op1: 32'h0, op2: 32'h0, cntl: 4'h6,
          rd: 5'd0, rw: 1'b0, ld: 1'b0, ill: 1'b0};
    return e;
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rfd);
    if (exm_regwrite && exm_rd != 5'd0 && exm_rd == rs) return exm_result;
    if (mwb_regwrite && mwb_rd != 5'd0 && mwb_rd == rs) return mwb_result;
    return rfd;
  endfunction

  function automatic exp_t ref_issue(input logic [31:0] ins, input logic [31:0] ipc,
                                     input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] imm);
    exp_t        e;
    logic [31:0] src2;
    e = '{bubble: 1'b0, valid: 1'b1, funct: ins[14:12], op1: 32'h0, op2: 32'h0, cntl: 4'h6,
          rd: ins[11:7], rw: 1'b1, ld: 1'b0, ill: 1'b0};
    src2 = (ins[6:0] == 7'h33) ? b : imm;
    case (ins[6:0])
      7'h33, 7'h13: begin
        e.op1 = a;
        e.op2 = src2;
        case (ins[14:12])
          3'd0: e.cntl = (ins[6:0] == 7'h33 && ins[30]) ? 4'h7 : 4'h6;
          3'd1: begin e.cntl = 4'h3; e.op2 = src2 & 32'h1F; end
          3'd2, 3'd3: e.cntl = 4'h7;
          3'd4: e.cntl = 4'h2;
          3'd5: begin e.cntl = ins[30] ? 4'h5 : 4'h4; e.op2 = src2 & 32'h1F; end
          3'd6: e.cntl = 4'h1;
          default: e.cntl = 4'h0;
        endcase
      end
      7'h03: begin e.op1 = a; e.op2 = imm; e.ld = 1'b1; end
      7'h23: begin e.op1 = a; e.op2 = imm; e.rw = 1'b0; end
      7'h37: e.op2 = imm;
      7'h17: begin e.op1 = ipc; e.op2 = imm; end
      7'h6F, 7'h67: begin e.op1 = ipc; e.op2 = 32'd4; end
      7'h63: begin e.cntl = 4'h7; e.op1 = a; e.op2 = b; e.rw = 1'b0; end
      default: begin e.rw = 1'b0; e.ill = 1'b1; end
    endcase
    return e;
  endfunction

  task automatic drive_id(input logic [31:0] ins, input logic [31:0] imm);
    id_valid    = 1'b1;
    id_instr    = ins;
    id_rs1_data = rf[ins[19:15]];
    id_rs2_data = rf[ins[24:20]];
    id_imm      = imm;
    pc          = pc + 32'd4;
    id_pc       = pc;
  endtask

  task automatic clear_fwd();
    exm_rd = '0; mwb_rd = '0; exm_regwrite = 1'b0; mwb_regwrite = 1'b0;
    exm_result = '0; mwb_result = '0; exm_is_load = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".valid"}, 32'(ex_valid), 32'd0);
    check({tag, ".cntl"}, 32'(ex_ALUcntl), 32'h6);
    check({tag, ".funct"}, 32'(ex_funct), 32'd0);
    check({tag, ".op1"}, ex_op1, 32'd0);
    check({tag, ".op2"}, ex_op2, 32'd0);
    check({tag, ".rd"}, 32'(ex_rd), 32'd0);
    check({tag, ".rw"}, 32'(ex_regwrite), 32'd0);
    check({tag, ".ld"}, 32'(ex_is_load), 32'd0);
    check({tag, ".ill"}, 32'(illegal), 32'd0);
    check({tag, ".stall_req"}, 32'(stall_req), 32'd0);
    m_prev = bubble();
    m_prev.bubble = 1'b0;
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, got valid=%0b expected an entry", tag, ex_valid);
    end else begin
      e = sb.pop_front();
      check({tag, ".valid"}, 32'(ex_valid), 32'(e.valid));
      check({tag, ".cntl"}, 32'(ex_ALUcntl), 32'(e.cntl));
      check({tag, ".funct"}, 32'(ex_funct), 32'(e.funct));
      check({tag, ".rw"}, 32'(ex_regwrite), 32'(e.rw));
      if (!e.bubble) begin
        check({tag, ".op1"}, ex_op1, e.op1);
        check({tag, ".op2"}, ex_op2, e.op2);
        check({tag, ".rd"}, 32'(ex_rd), 32'(e.rd));
        check({tag, ".ld"}, 32'(ex_is_load), 32'(e.ld));
        check({tag, ".ill"}, 32'(illegal), 32'(e.ill));
      end
      m_prev = e;
    end
  endtask

  // Called just after a falling edge with the cycle's inputs already driven.
  task automatic step(input string tag, input logic exp_stall);
    exp_t e;
    #1;
    check({tag, ".stall_req"}, 32'(stall_req), 32'(exp_stall));
    if (flush)                 e = bubble();
    else if (ex_stall)         e = m_prev;
    else if (exp_stall)        e = bubble();
    else if (id_valid)
      e = ref_issue(id_instr, id_pc, fwd(id_instr[19:15], id_rs1_data),
                    fwd(id_instr[24:20], id_rs2_data), id_imm);
    else                       e = bubble();
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_out(tag);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + 32'(i) * 32'h11;
    rf[0] = 32'h0;
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    rf[8] = 32'hF000_0000;
    rf[9] = 32'hFFFF_FFE3;

    // Reset with hazard-looking inputs: stall_req must stay low.
    ex_stall = 1'b1; exm_is_load = 1'b1; exm_rd = 5'd1;
    drive_id(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 32'h0);
    @(negedge clk); @(negedge clk);
    check_reset("reset");
    ex_stall = 1'b0; clear_fwd();
    rst_n = 1'b1;

    drive_id(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 32'h0);     step("sub", 1'b0);
    drive_id(enc_i(12'h025, 5'd1, 3'd1, 5'd6, 7'h13), 32'h25);        step("slli", 1'b0);
    drive_id(enc_r(7'h20, 5'd9, 5'd8, 3'd5, 5'd7, 7'h33), 32'h0);     step("sra", 1'b0);
    drive_id(enc_r(7'h00, 5'd9, 5'd8, 3'd5, 5'd7, 7'h33), 32'h0);     step("srl", 1'b0);
    drive_id(enc_i(12'h404, 5'd8, 3'd5, 5'd7, 7'h13), 32'h404);       step("srai", 1'b0);
    drive_id(enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd10, 7'h33), 32'h0);    step("slt", 1'b0);
    drive_id(enc_i(12'hFFF, 5'd1, 3'd3, 5'd10, 7'h13), 32'hFFFF_FFFF); step("sltiu", 1'b0);
    drive_id(enc_r(7'h00, 5'd2, 5'd1, 3'd4, 5'd11, 7'h33), 32'h0);    step("xor", 1'b0);
    drive_id(enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd11, 7'h33), 32'h0);    step("or", 1'b0);
    drive_id(enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd11, 7'h33), 32'h0);    step("and", 1'b0);
    drive_id(enc_i(12'hFFC, 5'd1, 3'd0, 5'd11, 7'h13), 32'hFFFF_FFFC); step("addi", 1'b0);
    drive_id(enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd4, 7'h23), 32'd4);     step("sw", 1'b0);
    drive_id({20'h12345, 5'd12, 7'h37}, 32'h1234_5000);               step("lui", 1'b0);
    drive_id({20'h00001, 5'd13, 7'h17}, 32'h0000_1000);               step("auipc", 1'b0);
    drive_id({20'h00000, 5'd1, 7'h6F}, 32'h0);                        step("jal", 1'b0);
    drive_id(enc_i(12'h000, 5'd1, 3'd0, 5'd1, 7'h67), 32'h0);         step("jalr", 1'b0);
    drive_id(enc_r(7'h00, 5'd2, 5'd1, 3'd1, 5'd0, 7'h63), 32'h10);    step("bne", 1'b0);
    drive_id(32'hFFFF_FFFF, 32'h55);                                  step("illegal", 1'b0);

    // Forwarding priority and the rd=0 exclusion.
    exm_rd = 5'd3; mwb_rd = 5'd3; exm_regwrite = 1'b1; mwb_regwrite = 1'b1;
    exm_result = 32'hAA; mwb_result = 32'hBB;
    drive_id(enc_r(7'h00, 5'd2, 5'd3, 3'd0, 5'd7, 7'h33), 32'h0);     step("fwd_exm", 1'b0);
    exm_regwrite = 1'b0;
    drive_id(enc_r(7'h00, 5'd2, 5'd3, 3'd0, 5'd7, 7'h33), 32'h0);     step("fwd_mwb", 1'b0);
    exm_rd = 5'd2; exm_regwrite = 1'b1; exm_result = 32'hCC;
    drive_id(enc_r(7'h00, 5'd2, 5'd3, 3'd0, 5'd7, 7'h33), 32'h0);     step("fwd_both", 1'b0);
    exm_rd = 5'd0; mwb_rd = 5'd0;
    drive_id(enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd7, 7'h33), 32'h0);     step("fwd_x0", 1'b0);
    clear_fwd();

    // Load-use: one bubble, then the dependent ADD issues with MEM/WB data.
    drive_id(enc_i(12'h008, 5'd1, 3'd2, 5'd4, 7'h03), 32'd8);         step("lw", 1'b0);
    exm_rd = 5'd4; exm_regwrite = 1'b1; exm_is_load = 1'b1; exm_result = 32'hDEAD;
    drive_id(enc_r(7'h00, 5'd4, 5'd4, 3'd0, 5'd5, 7'h33), 32'h0);     step("lu_bubble", 1'b1);
    exm_rd = 5'd0; exm_regwrite = 1'b0; exm_is_load = 1'b0;
    mwb_rd = 5'd4; mwb_regwrite = 1'b1; mwb_result = 32'h55;
    id_pc = id_pc;                                                     step("lu_issue", 1'b0);
    // ADDI's rs2 field aliases the load's rd but is an immediate, not a source.
    clear_fwd();
    exm_rd = 5'd4; exm_regwrite = 1'b1; exm_is_load = 1'b1;
    drive_id(enc_i(12'h004, 5'd6, 3'd0, 5'd5, 7'h13), 32'd4);         step("lu_imm", 1'b0);
    clear_fwd();

    // Downstream hold, flush priority, idle.
    drive_id(enc_r(7'h00, 5'd2, 5'd1, 3'd4, 5'd9, 7'h33), 32'h0);     step("pre_hold", 1'b0);
    ex_stall = 1'b1;
    drive_id(enc_r(7'h20, 5'd1, 5'd2, 3'd0, 5'd12, 7'h33), 32'h0);    step("hold1", 1'b1);
    drive_id(32'hFFFF_FFFF, 32'h0);                                   step("hold2", 1'b1);
    flush = 1'b1;
    drive_id(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd12, 7'h33), 32'h0);    step("flush_stall", 1'b1);
    ex_stall = 1'b0;
    drive_id(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd12, 7'h33), 32'h0);    step("flush", 1'b0);
    flush = 1'b0;
    id_valid = 1'b0;                                                  step("idle", 1'b0);
    drive_id(32'hFFFF_FFFF, 32'h0);                                   step("illegal2", 1'b0);

    // Asynchronous reset mid-stream with a valid issue pending and ex_stall high.
    drive_id(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd13, 7'h33), 32'h0);
    ex_stall = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset("rst_async");
    @(posedge clk); #1 check_reset("rst_hold");
    @(negedge clk);
    rst_n = 1'b1; ex_stall = 1'b0;
    drive_id(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 32'h0);     step("post_rst", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
